// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined): synchronises rx, samples each bit at mid-period.
// Latency: start-bit falling edge to rx_dout_vld = 3 + HALF_CNT + 9*BIT_CNT_MAX + 1 clocks (8N1).
// No backpressure: rx_dout_vld is a single-cycle pulse the consumer must take; rx_dout holds until the next byte.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_dout,
    output logic       rx_dout_vld,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int BIT_CNT_MAX = CLK_FREQ / BAUD;
    localparam int HALF_CNT    = BIT_CNT_MAX / 2;
    localparam int CNT_W       = $clog2(BIT_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    logic             fall;
    logic [CNT_W-1:0] bit_cnt;
    logic             cnt_last;
    logic             cnt_clr;
    logic [2:0]       data_idx;
    logic [7:0]       shift_reg;
    logic             shift_en;
    logic             stop_smp;
`ifdef UART_RX_PARITY_EN
    logic             par_smp;
    logic             par_bit;
`endif

    // Two-flop synchroniser plus one delay flop for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall     = rx_s3 & ~rx_s2;
    assign cnt_last = (bit_cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes; START realigns the counter so later samples land mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == CNT_HALF) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    shift_en = 1'b1;
                    if (data_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-period counter: held at zero in IDLE, cleared on realignment, wraps every bit period.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || cnt_clr || cnt_last) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Data bit index: only advances while collecting data bits.
    always_ff @(posedge clk) begin
        if (rst || state != DATA) begin
            data_idx <= 3'd0;
        end else if (shift_en) begin
            data_idx <= data_idx + 3'd1;
        end
    end

    // Capture data bits LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 8'h00;
        end else if (shift_en) begin
            shift_reg[data_idx] <= rx_s2;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the received parity bit and flag an even-parity mismatch alongside the stop-bit decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_smp) begin
                par_bit <= rx_s2;
            end
            parity_err <= stop_smp & (par_bit ^ (^shift_reg));
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Deliver the byte on a good stop bit, otherwise pulse frame_err and keep the previous byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_dout     <= 8'h00;
            rx_dout_vld <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_dout_vld <= 1'b0;
            frame_err   <= 1'b0;
            if (stop_smp) begin
                if (rx_s2) begin
                    rx_dout     <= shift_reg;
                    rx_dout_vld <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: drives the serial line bit by bit and scores the received bytes and pulses.
// Latency of the first byte is measured against the start-bit edge.
// The line driver has no backpressure; all stimulus is time-based.
module tb_uart_rx;

    localparam int BIT     = 50_000_000 / 115200;          // 434 clocks per bit
    localparam int LAT_EXP = 3 + (BIT / 2) + 9 * BIT + 1;  // 4127 clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_dout_vld;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         start_cyc  = 0;
    int         last_vld_cyc = 0;
    int         fe_cnt     = 0;
    int         pe_cnt     = 0;
    int         pe_vld_cnt = 0;
    int         busy_cnt   = 0;
    int         lat;
    logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_dout     (rx_dout),
        .rx_dout_vld (rx_dout_vld),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_dout_vld) begin
            got_q.push_back(rx_dout);
            last_vld_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (parity_err && rx_dout_vld) pe_vld_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; holds the line for one bit period.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Global time bound.
    initial begin
        #1_600_000;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout", {24'h0, rx_dout}, 32'h00);
        check("rst_vld", {31'h0, rx_dout_vld}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_perr", {31'h0, parity_err}, 32'h0);
        rst = 1'b0;
        idle(20);

        // Single byte with latency measurement.
        send_frame(8'hAA, 1'b1);
        idle(50);
        lat = last_vld_cyc - start_cyc;
        check("aa_count", got_q.size(), 1);
        check("aa_data", {24'h0, got_q[0]}, 32'hAA);
        check("aa_latency", (lat >= LAT_EXP - 2 && lat <= LAT_EXP + 2) ? LAT_EXP : lat, LAT_EXP);
        check("aa_busy_low", {31'h0, busy}, 32'h0);
        check("aa_ferr_cnt", fe_cnt, 0);
        check("aa_dout_held", {24'h0, rx_dout}, 32'hAA);

        // Back-to-back frames with no idle gap.
        send_frame(8'h55, 1'b1);
        send_frame(8'hEF, 1'b1);
        send_frame(8'hAE, 1'b1);
        send_frame(8'h11, 1'b1);
        idle(50);
        check("b2b_count", got_q.size(), 5);
        check("b2b_0", {24'h0, got_q[1]}, 32'h55);
        check("b2b_1", {24'h0, got_q[2]}, 32'hEF);
        check("b2b_2", {24'h0, got_q[3]}, 32'hAE);
        check("b2b_3", {24'h0, got_q[4]}, 32'h11);
        check("b2b_ferr_cnt", fe_cnt, 0);

        // 5-clock low glitch: false start rejected at half bit.
        busy_cnt = 0;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(600);
        check("glitch_busy_len", (busy_cnt >= 210 && busy_cnt <= 226) ? 218 : busy_cnt, 218);
        check("glitch_no_vld", got_q.size(), 5);
        check("glitch_no_ferr", fe_cnt, 0);
        check("glitch_busy_low", {31'h0, busy}, 32'h0);

        // Stop bit forced low.
        send_frame(8'h33, 1'b0);
        idle(50);
        check("ferr_cnt", fe_cnt, 1);
        check("ferr_no_vld", got_q.size(), 5);
        check("ferr_dout_kept", {24'h0, rx_dout}, 32'h11);
        send_frame(8'h44, 1'b1);
        idle(50);
        check("after_ferr_count", got_q.size(), 6);
        check("after_ferr_data", {24'h0, got_q[5]}, 32'h44);

        // Break: line held low for 12 bit times gives a single frame error.
        rx = 1'b0;
        idle(12 * BIT);
        check("break_busy_low", {31'h0, busy}, 32'h0);
        rx = 1'b1;
        idle(500);
        check("break_ferr_once", fe_cnt, 2);
        check("break_no_vld", got_q.size(), 6);

        // Reset mid-data of 8'h22 (transmitter aborts too, line returns high).
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        idle(200);
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("mid_rst_dout", {24'h0, rx_dout}, 32'h00);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_vld", {31'h0, rx_dout_vld}, 32'h0);
        check("mid_rst_ferr", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        idle(100);
        send_frame(8'h22, 1'b1);
        idle(50);
        check("after_rst_count", got_q.size(), 7);
        check("after_rst_data", {24'h0, got_q[6]}, 32'h22);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(50);
        check("par_ok_count", got_q.size(), 8);
        check("par_ok_data", {24'h0, got_q[7]}, 32'h07);
        check("par_ok_perr", pe_cnt, 0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(50);
        par_flip = 1'b0;
        check("par_bad_count", got_q.size(), 9);
        check("par_bad_data", {24'h0, got_q[8]}, 32'h07);
        check("par_bad_perr", pe_cnt, 1);
        check("par_bad_with_vld", pe_vld_cnt, 1);
`else
        check("no_parity_err", pe_cnt, 0);
`endif
        check("total_ferr", fe_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
